shift_arbiter: RTL
==================

// Module: shift_arbiter
// PURPOSE
//  Shares one 32-bit shift unit (LSL/LSR/ASR/ROR) between two requesters
//  (req0: operand-2 path, req1: address/multi-cycle path) using valid/ready
//  handshakes. Arbitrates, issues the shift and holds the result in a 1-entry
//  output register until consumed. Sits between the decode/issue logic and the ALU.
// PARAMETERS
//  TAG_W        4  width of the opaque tag carried from request to result
//  PRIO_MODE    0  0 = round-robin; 1 = fixed priority to req0 with starvation guard
//  STARVE_LIMIT 4  PRIO_MODE=1 only: after this many req0 grants while req1 waits, req1 gets one grant
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-low reset
//  reqN_valid   in   1      N=0,1: request present
//  reqN_ready   out  1      N=0,1: request accepted this cycle (valid&&ready = handshake)
//  reqN_data    in   32     N=0,1: operand to shift
//  reqN_amt     in   5      N=0,1: shift amount 0..31
//  reqN_type    in   2      N=0,1: 00 LSL, 01 LSR, 10 ASR, 11 ROR
//  reqN_tag     in   TAG_W  N=0,1: returned unchanged on res_tag
//  res_valid    out  1      result register holds a valid result
//  res_ready    in   1      consumer accepts result
//  res_data     out  32     shifted value
//  res_src      out  1      0 = from req0, 1 = from req1
//  res_tag      out  TAG_W  tag of the request that produced res_data
// BEHAVIOUR
//  - Reset (async assert, sync release): res_valid=0, res_data=0, res_src=0, res_tag=0,
//    res_carry=0, rr pointer last=1 (req0 wins first), starve counter=0. Pending result is dropped.
//  - States: EMPTY (res_valid=0), FULL (res_valid=1). accept = EMPTY || (FULL && res_ready).
//  - Grant (combinational): only requesters with valid=1 compete; reqN_ready = accept && grant==N;
//    ready never asserted to a requester with valid=0. Requesters hold valid/data/amt/type/tag until handshake.
//  - Round-robin: both valid -> grant to !last; one valid -> that one. last updates only on handshake.
//  - PRIO_MODE=1: req0 wins unless req1 valid and starve count==STARVE_LIMIT; count increments on each
//    req0 grant while req1 valid, clears on req1 grant or when req1 not valid.
//  - Latency 1: handshake in cycle N -> res_valid/res_data/res_src/res_tag updated at edge ending cycle N.
//  - Throughput 1/cycle: FULL && res_ready && new handshake -> register reloads, stays FULL.
//    FULL && res_ready && no handshake -> EMPTY. FULL && !res_ready -> outputs held stable, all ready=0.
//  - Shift semantics (32-bit, amt mod 32): LSL/LSR zero-fill; ASR sign-fills from data[31] (must be
//    computed as signed, not unsigned >>>); ROR rotate right; amt=0 -> result = data for every type.
// CONFIGURATION
//  SHIFT_CARRY_EN defined: adds reqN_cin (in, 1) and res_carry (out, 1), registered with res_data.
//   res_carry: amt=0 -> reqN_cin; LSL -> data[32-amt]; LSR/ASR -> data[amt-1]; ROR -> result[31].
//  SHIFT_CARRY_EN undefined: those ports and their logic are absent; everything else identical.
// TESTING
//  1. req0 only: data=0x0000_0001 amt=4 LSL, res_ready=1 -> next cycle res_data=0x0000_0010, res_src=0, tag echoed.
//  2. Both valid every cycle, RR, res_ready=1 -> res_src sequence 0,1,0,1,... one result per cycle.
//  3. res_ready=0 for 3 cycles while FULL -> res_* stable, req0_ready=req1_ready=0; res_ready=1 -> reload same cycle.
//  4. ASR 0x8000_0000 amt 31 -> 0xFFFF_FFFF; ROR 0x0000_0001 amt 1 -> 0x8000_0000; ROR 0x1234_5678 amt 0 -> 0x1234_5678.
//  5. PRIO_MODE=1, STARVE_LIMIT=4, both valid continuously -> grants 0,0,0,0,1 repeating.
//  6. reset low while FULL -> res_valid=0 immediately (no clock); SHIFT_CARRY_EN: LSR 0x3 amt 1 -> res_carry=1.

Source files
------------

// File: rtl/shift_arbiter.sv
// Two-requester arbiter in front of a shared 32-bit LSL/LSR/ASR/ROR unit with a 1-entry result register.
// Optional carry-out path enabled by defining SHIFT_CARRY_EN.
module shift_arbiter #(
    parameter int TAG_W        = 4,
    parameter int PRIO_MODE    = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_data,
    input  logic [4:0]       req0_amt,
    input  logic [1:0]       req0_type,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_data,
    input  logic [4:0]       req1_amt,
    input  logic [1:0]       req1_type,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_src,
    output logic [TAG_W-1:0] res_tag
`ifdef SHIFT_CARRY_EN
    ,
    input  logic             req0_cin,
    input  logic             req1_cin,
    output logic             res_carry
`endif
);

    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 2);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t             state;
    logic               last;
    logic [CNT_W-1:0]   starve;
    logic               accept;
    logic               gnt;
    logic               hs;

    logic [DATA_W-1:0]  data_p0;
    logic [4:0]         amt_p0;
    logic [1:0]         type_p0;
    logic [TAG_W-1:0]   tag_p0;
    logic [DATA_W-1:0]  shift_p0;

    logic [DATA_W-1:0]  data_p1;
    logic               src_p1;
    logic [TAG_W-1:0]   tag_p1;

    function automatic logic [DATA_W-1:0] shift_op(input logic [DATA_W-1:0] d,
                                                   input logic [4:0]        a,
                                                   input logic [1:0]        t);
        logic signed [DATA_W-1:0] sd;
        logic signed [DATA_W-1:0] asr;
        logic [2*DATA_W-1:0]      rot;
        sd  = d;
        asr = sd >>> a;
        rot = {d, d} >> a;
        case (t)
            2'b00:   return d << a;
            2'b01:   return d >> a;
            2'b10:   return asr;
            default: return rot[DATA_W-1:0];
        endcase
    endfunction

`ifdef SHIFT_CARRY_EN
    logic cin_p0;
    logic carry_p0;
    logic carry_p1;

    // Last bit shifted out; 5'd0 - a is 32 - a for the non-zero amounts that reach it.
    function automatic logic carry_op(input logic [DATA_W-1:0] d,
                                      input logic [4:0]        a,
                                      input logic [1:0]        t,
                                      input logic              cin,
                                      input logic [DATA_W-1:0] r);
        if (a == 5'd0)
            return cin;
        case (t)
            2'b00:   return d[5'd0 - a];
            2'b01,
            2'b10:   return d[a - 5'd1];
            default: return r[DATA_W-1];
        endcase
    endfunction
`endif

    // Stage p0: arbitration and shift of the selected request
    always_comb begin
        accept = (state == EMPTY) || res_ready;
        if (PRIO_MODE == 1)
            gnt = req1_valid && (!req0_valid || (starve == CNT_W'(STARVE_LIMIT)));
        else
            gnt = (req0_valid && req1_valid) ? !last : req1_valid;
        hs         = accept && (req0_valid || req1_valid);
        req0_ready = accept && req0_valid && !gnt;
        req1_ready = accept && req1_valid && gnt;
        data_p0    = gnt ? req1_data : req0_data;
        amt_p0     = gnt ? req1_amt  : req0_amt;
        type_p0    = gnt ? req1_type : req0_type;
        tag_p0     = gnt ? req1_tag  : req0_tag;
        shift_p0   = shift_op(data_p0, amt_p0, type_p0);
`ifdef SHIFT_CARRY_EN
        cin_p0     = gnt ? req1_cin : req0_cin;
        carry_p0   = carry_op(data_p0, amt_p0, type_p0, cin_p0, shift_p0);
`endif
    end

    // Stage p1: result register and arbitration state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= EMPTY;
            last     <= 1'b1;
            starve   <= '0;
            data_p1  <= '0;
            src_p1   <= 1'b0;
            tag_p1   <= '0;
`ifdef SHIFT_CARRY_EN
            carry_p1 <= 1'b0;
`endif
        end else begin
            case (state)
                EMPTY:   if (hs) state <= FULL;
                FULL:    if (res_ready && !hs) state <= EMPTY;
                default: state <= EMPTY;
            endcase
            if (hs) begin
                data_p1  <= shift_p0;
                src_p1   <= gnt;
                tag_p1   <= tag_p0;
                last     <= gnt;
`ifdef SHIFT_CARRY_EN
                carry_p1 <= carry_p0;
`endif
            end
            if (PRIO_MODE == 1) begin
                if (!req1_valid || (hs && gnt))
                    starve <= '0;
                else if (hs)
                    starve <= starve + 1'b1;
            end
        end
    end

    assign res_valid = (state == FULL);
    assign res_data  = data_p1;
    assign res_src   = src_p1;
    assign res_tag   = tag_p1;
`ifdef SHIFT_CARRY_EN
    assign res_carry = carry_p1;
`endif

endmodule
